// File: rtl/gfx_strip_unpack_pkg.sv
`default_nettype none
// ============================================================================
// Module : gfx_pkg
// Brief  : Shared types and helpers for the strip unpacker.
// Rev    : 1.0  initial release
// ============================================================================
package gfx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } gfx_unpack_state_t;

  localparam int unsigned GFX_COLOR_W = 32;

  // Geometry fields use 0 as an alias for 1.
  function automatic logic [15:0] gfx_nz16(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gfx_strip_unpack_if.sv
`default_nettype none
// ============================================================================
// Module : gfx_strip_unpack_if
// Brief  : Strip-in / pixel-out handshake bundle of the strip unpacker.
// Rev    : 1.0  initial release
// ============================================================================
interface gfx_strip_unpack_if #(
  parameter int SW = 256
);
  logic [SW-1:0] strip_i;
  logic          strip_valid_i;
  logic          strip_ready_o;
  logic          pix_valid_o;
  logic          pix_ready_i;
  logic [31:0]   color_o;
  logic [15:0]   x_o;
  logic [15:0]   y_o;
  logic          eof_o;

  modport slave (
    input  strip_i, strip_valid_i, pix_ready_i,
    output strip_ready_o, pix_valid_o, color_o, x_o, y_o, eof_o
  );

  modport master (
    output strip_i, strip_valid_i, pix_ready_i,
    input  strip_ready_o, pix_valid_o, color_o, x_o, y_o, eof_o
  );
endinterface
`default_nettype wire

// File: rtl/gfx_strip_unpack_extract.sv
`default_nettype none
// ============================================================================
// Module : gfx_pixel_extract
// Brief  : Masks the low cbpp+1 bits of the shift register into a color.
// Rev    : 1.0  initial release
// ============================================================================
module gfx_pixel_extract
  import gfx_pkg::*;
(
  input  logic [GFX_COLOR_W-1:0] i_data,
  input  logic [4:0]             i_cbpp,
  output logic [GFX_COLOR_W-1:0] o_color
);

  logic [GFX_COLOR_W-1:0] w_mask;

  // Shifting ~1 keeps cbpp=31 from needing a 33-bit intermediate.
  assign w_mask  = ~({{(GFX_COLOR_W-1){1'b1}}, 1'b0} << i_cbpp);
  assign o_color = i_data & w_mask;

endmodule
`default_nettype wire

// File: rtl/gfx_strip_unpack.sv
`default_nettype none
// ============================================================================
// Module : gfx_strip_unpack
// Brief  : Unpacks memory strips into raster-ordered pixels with x/y/eof.
// Rev    : 1.0  initial release
// ============================================================================
module gfx_strip_unpack
  import gfx_pkg::*;
#(
  parameter int SW = 256,
  parameter int BN = $clog2(SW) - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [5:0]  bpp_i,
  input  logic [4:0]  cbpp_i,
  input  logic [9:0]  pps_i,
  input  logic [15:0] bmp_width_i,
  input  logic [15:0] bmp_height_i,
  gfx_strip_unpack_if.slave bus
);

  // One extra bit so a full-strip pitch (bpp+1 == SW) does not wrap to 0.
  localparam int SHW = BN + 2;

  gfx_unpack_state_t r_state, w_state_nxt;

  logic [SW-1:0]  r_shift;
  logic [9:0]     r_cnt;
  logic [15:0]    r_x, r_y;
  logic [15:0]    w_pps, w_w, w_h;
  logic [SHW-1:0] w_sh;
  logic           w_last_x, w_last_y, w_last_pix;
  logic           w_valid, w_ready, w_hs, w_acc;

  assign w_pps      = gfx_nz16({6'd0, pps_i});
  assign w_w        = gfx_nz16(bmp_width_i);
  assign w_h        = gfx_nz16(bmp_height_i);
  assign w_sh       = SHW'(bpp_i) + SHW'(1);
  assign w_last_x   = (r_x == w_w - 16'd1);
  assign w_last_y   = (r_y == w_h - 16'd1);
  assign w_last_pix = ({6'd0, r_cnt} == w_pps - 16'd1) || w_last_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_ready     = 1'b0;
    w_hs        = 1'b0;
    w_acc       = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        w_acc   = bus.strip_valid_i;
        if (w_acc) w_state_nxt = EMIT;
      end
      EMIT: begin
        w_valid = 1'b1;
        w_hs    = bus.pix_ready_i;
        // Last pixel of the strip frees the register for a zero-bubble reload.
        if (w_hs && w_last_pix) begin
          w_ready     = 1'b1;
          w_acc       = bus.strip_valid_i;
          w_state_nxt = w_acc ? EMIT : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (start_i) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (start_i) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      if (w_hs) begin
        r_shift <= r_shift >> w_sh;
        r_cnt   <= r_cnt + 10'd1;
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? 16'd0 : r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
      if (w_acc) begin
        r_shift <= bus.strip_i;
        r_cnt   <= '0;
      end
    end
  end

  gfx_pixel_extract u_extract (
    .i_data  (r_shift[GFX_COLOR_W-1:0]),
    .i_cbpp  (cbpp_i),
    .o_color (bus.color_o)
  );

  assign bus.strip_ready_o = w_ready;
  assign bus.pix_valid_o   = w_valid;
  assign bus.x_o           = r_x;
  assign bus.y_o           = r_y;
  assign bus.eof_o         = w_valid && w_last_x && w_last_y;

endmodule
`default_nettype wire

// File: tb/tb_gfx_strip_unpack.sv
`default_nettype none
// ============================================================================
// Module : tb_gfx_strip_unpack
// Brief  : Randomized bench for gfx_strip_unpack against a raster-walk model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gfx_strip_unpack;

  typedef struct packed {
    logic [31:0] c;
    logic [15:0] x;
    logic [15:0] y;
    logic        e;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  bpp;
  logic [4:0]  cbpp;
  logic [9:0]  pps;
  logic [15:0] bw, bh;

  gfx_strip_unpack_if #(.SW(256)) bus ();

  gfx_strip_unpack #(.SW(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .bpp_i        (bpp),
    .cbpp_i       (cbpp),
    .pps_i        (pps),
    .bmp_width_i  (bw),
    .bmp_height_i (bh),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mx, my, pix_cnt;
  pix_t exp_q[$];
  logic [255:0] src_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_cfg(input int b, input int cb, input int p, input int w, input int h);
    bpp  = 6'(b);
    cbpp = 5'(cb);
    pps  = 10'(p);
    bw   = 16'(w);
    bh   = 16'(h);
  endtask

  // Walk the frame the way memory was packed: up to pps pixels, never past end of line.
  task automatic model_strip(input logic [255:0] s);
    int w, h, p;
    logic [63:0]  mask;
    logic [255:0] t;
    pix_t px;
    w = (bw == 0) ? 1 : int'(bw);
    h = (bh == 0) ? 1 : int'(bh);
    p = (pps == 0) ? 1 : int'(pps);
    mask = (64'd1 << (int'(cbpp) + 1)) - 64'd1;
    for (int k = 0; k < p; k++) begin
      t    = s >> (k * (int'(bpp) + 1));
      px.c = t[31:0] & mask[31:0];
      px.x = 16'(mx);
      px.y = 16'(my);
      px.e = (mx == w - 1) && (my == h - 1);
      exp_q.push_back(px);
      if (mx == w - 1) begin
        mx = 0;
        my = (my == h - 1) ? 0 : my + 1;
        break;
      end
      mx++;
    end
  endtask

  task automatic new_frame();
    @(negedge clk);
    bus.strip_valid_i = 1'b0;
    bus.pix_ready_i   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.delete();
    mx = 0; my = 0; pix_cnt = 0;
  endtask

  task automatic run_stream(input int ready_pct, input int valid_pct,
                            input int stall_at, input int abort_at, input bit abort_rst);
    int   cyc = 0;
    int   stall_cnt = 0;
    bit   aborted = 1'b0;
    bit   rdy, hs, exp_rdy;
    pix_t p;
    while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      rst = 1'b0;
      start = 1'b0;
      if (!aborted && abort_at >= 0 && pix_cnt == abort_at && exp_q.size() > 0) begin
        aborted = 1'b1;
        bus.pix_ready_i   = 1'b0;
        bus.strip_valid_i = 1'b0;
        if (abort_rst) rst = 1'b1;
        else           start = 1'b1;
        #1;
        if (abort_rst) begin
          check_val("rst_pix_valid", bus.pix_valid_o, 0);
          check_val("rst_eof", bus.eof_o, 0);
          check_val("rst_strip_ready", bus.strip_ready_o, 1);
          check_val("rst_x", bus.x_o, 0);
        end
        exp_q.delete();
        mx = 0; my = 0;
        continue;
      end
      if (stall_at >= 0 && pix_cnt == stall_at && stall_cnt < 5) begin
        rdy = 1'b0;
        stall_cnt++;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      bus.pix_ready_i   = rdy;
      bus.strip_valid_i = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
      bus.strip_i       = (src_q.size() > 0) ? src_q[0] : '0;
      #1;
      check_val("pix_valid", bus.pix_valid_o, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        p = exp_q[0];
        check_val("color", bus.color_o, p.c);
        check_val("x", bus.x_o, p.x);
        check_val("y", bus.y_o, p.y);
        check_val("eof", bus.eof_o, p.e);
      end
      hs      = (exp_q.size() > 0) && rdy;
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && hs);
      check_val("strip_ready", bus.strip_ready_o, exp_rdy);
      if (hs) begin
        void'(exp_q.pop_front());
        pix_cnt++;
      end
      if (bus.strip_valid_i && exp_rdy) model_strip(src_q.pop_front());
    end
    if (cyc >= 20000) check_val("timeout", 1, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    bus.strip_valid_i = 1'b0;
    #1;
    check_val("idle_pix_valid", bus.pix_valid_o, 0);
    check_val("idle_strip_ready", bus.strip_ready_o, 1);
  endtask

  function automatic logic [255:0] rand_strip();
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  initial begin
    logic [255:0] s;
    int b, cb, pmax;
    rst = 1'b1;
    start = 1'b0;
    bus.strip_i = '0;
    bus.strip_valid_i = 1'b0;
    bus.pix_ready_i = 1'b0;
    set_cfg(7, 7, 32, 64, 2);
    mx = 0; my = 0; pix_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_strip_ready", bus.strip_ready_o, 1);
    check_val("reset_pix_valid", bus.pix_valid_o, 0);
    check_val("reset_eof", bus.eof_o, 0);
    check_val("reset_x", bus.x_o, 0);
    check_val("reset_y", bus.y_o, 0);
    check_val("reset_color", bus.color_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post_reset_ready", bus.strip_ready_o, 1);

    // Byte ramp: pixel k carries value k.
    for (int k = 0; k < 32; k++) s[8*k +: 8] = 8'(k);
    src_q.push_back(s);
    run_stream(100, 100, -1, -1, 0);

    // Four back-to-back strips fill a 64x2 frame.
    new_frame();
    for (int i = 0; i < 4; i++) src_q.push_back(rand_strip());
    run_stream(100, 100, -1, -1, 0);

    new_frame();
    set_cfg(15, 11, 16, 64, 2);
    s = rand_strip();
    s[15:0] = 16'hABCD;
    src_q.push_back(s);
    run_stream(100, 100, -1, -1, 0);

    // Short lines truncate a strip.
    new_frame();
    set_cfg(7, 7, 32, 20, 2);
    for (int i = 0; i < 3; i++) src_q.push_back(rand_strip());
    run_stream(100, 100, -1, -1, 0);

    new_frame();
    set_cfg(7, 7, 32, 64, 2);
    src_q.push_back(rand_strip());
    run_stream(100, 100, 3, -1, 0);

    new_frame();
    for (int i = 0; i < 2; i++) src_q.push_back(rand_strip());
    run_stream(100, 100, -1, 10, 0);

    new_frame();
    for (int i = 0; i < 2; i++) src_q.push_back(rand_strip());
    run_stream(100, 100, -1, 10, 1);

    // Zero geometry aliases to 1x1 frames with one pixel per strip.
    new_frame();
    set_cfg(7, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) src_q.push_back(rand_strip());
    run_stream(80, 80, -1, -1, 0);

    for (int r = 0; r < 8; r++) begin
      b    = $urandom_range(63);
      cb   = $urandom_range((b > 31) ? 31 : b);
      pmax = 256 / (b + 1);
      new_frame();
      set_cfg(b, cb, $urandom_range(pmax, 1), $urandom_range(40, 1), $urandom_range(3, 1));
      for (int i = 0; i < 4; i++) src_q.push_back(rand_strip());
      run_stream(70, 60, -1, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
